// File: rtl/dualram_if.sv
// Bus bundle for the ping-pong RAM: bank role select, write port, read address and registered read data.
interface dualram_if;
  logic        rnw;
  logic        din_valid;
  logic [7:0]  be;
  logic [2:0]  wa;
  logic [2:0]  ra;
  logic [63:0] di;
  logic [63:0] dout;

  modport master (
    output rnw, din_valid, be, wa, ra, di,
    input  dout
  );

  modport slave (
    input  rnw, din_valid, be, wa, ra, di,
    output dout
  );
endinterface

// File: rtl/dualram.sv
// Double-buffered 2 x 8 x 64-bit RAM: one bank takes byte-masked writes while the other is read.
module dualram (
  input  logic       clk,
  input  logic       rst_n,
  dualram_if.slave   bus
);

  logic [63:0] bank1_q [8];
  logic [63:0] bank2_q [8];
  logic [63:0] dout_q;

  logic [63:0] wrOld;
  logic [63:0] wrWord_d;
  logic [63:0] dout_d;

  // Merge the masked lanes with the current write-bank word; read side always uses the other bank.
  always_comb begin
    wrOld    = bus.rnw ? bank2_q[bus.wa] : bank1_q[bus.wa];
    wrWord_d = wrOld;
    for (int i = 0; i < 8; i++) begin
      if (!bus.be[i]) begin
        wrWord_d[8*i +: 8] = bus.di[8*i +: 8];
      end
    end
    dout_d = bus.rnw ? bank1_q[bus.ra] : bank2_q[bus.ra];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 8; k++) begin
        bank1_q[k] <= 64'h0;
        bank2_q[k] <= 64'h0;
      end
      dout_q <= 64'h0;
    end else begin
      if (bus.din_valid && !bus.rnw) begin
        bank1_q[bus.wa] <= wrWord_d;
      end
      if (bus.din_valid && bus.rnw) begin
        bank2_q[bus.wa] <= wrWord_d;
      end
      dout_q <= dout_d;
    end
  end

  assign bus.dout = dout_q;

endmodule

// File: tb/tb_dualram.sv
// Directed, table-driven bench for dualram with hand-computed expectations.
module tb_dualram;

  typedef struct {
    logic        rnw;
    logic        dinValid;
    logic [7:0]  be;
    logic [2:0]  wa;
    logic [2:0]  ra;
    logic [63:0] di;
    logic [63:0] expDout;
  } vecT;

  logic clk;
  logic rst_n;
  dualram_if bus ();

  int assertCount;
  int failCount;

  dualram dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: dout=%h expected=%h", name, actual, expected);
    end
  endtask

  // Drive a vector mid-cycle, let one rising edge consume it, then sample dout just after.
  task automatic applyStimulus(input vecT v);
    @(negedge clk);
    bus.rnw       = v.rnw;
    bus.din_valid = v.dinValid;
    bus.be        = v.be;
    bus.wa        = v.wa;
    bus.ra        = v.ra;
    bus.di        = v.di;
    @(posedge clk);
    #1;
  endtask

  task automatic readCheck(input string name, input logic rnwSel, input logic [2:0] addr, input logic [63:0] expected);
    vecT v;
    v = '{rnwSel, 1'b0, 8'hFF, 3'd0, addr, 64'h0, expected};
    applyStimulus(v);
    checkOutput(name, bus.dout, expected);
  endtask

  task automatic writeOnly(input logic rnwSel, input logic [2:0] addr, input logic [63:0] data);
    vecT v;
    v = '{rnwSel, 1'b1, 8'h00, addr, 3'd0, data, 64'h0};
    applyStimulus(v);
  endtask

  vecT vecs [20];

  initial begin
    assertCount = 0;
    failCount   = 0;

    vecs[0]  = '{1'b0, 1'b1, 8'h00, 3'd1, 3'd0, 64'h123456789ABCDEF0, 64'h0};
    vecs[1]  = '{1'b0, 1'b1, 8'h00, 3'd7, 3'd7, 64'h318A76CFCF768A31, 64'h0};
    vecs[2]  = '{1'b0, 1'b1, 8'h00, 3'd3, 3'd3, 64'h7631CF8A8ACF3176, 64'h0};
    vecs[3]  = '{1'b1, 1'b0, 8'h00, 3'd0, 3'd1, 64'h0, 64'h123456789ABCDEF0};
    vecs[4]  = '{1'b1, 1'b0, 8'h00, 3'd0, 3'd7, 64'h0, 64'h318A76CFCF768A31};
    vecs[5]  = '{1'b0, 1'b1, 8'hF0, 3'd3, 3'd0, 64'hFFFFFFFFFFFFFFFF, 64'h0};
    vecs[6]  = '{1'b1, 1'b0, 8'h00, 3'd0, 3'd3, 64'h0, 64'h7631CF8AFFFFFFFF};
    vecs[7]  = '{1'b0, 1'b0, 8'h00, 3'd2, 3'd2, 64'hAA5500FF0055AAFF, 64'h0};
    vecs[8]  = '{1'b1, 1'b0, 8'h00, 3'd0, 3'd2, 64'h0, 64'h0};
    vecs[9]  = '{1'b1, 1'b1, 8'h00, 3'd1, 3'd1, 64'hB0B1B2B3B4B5B6B7, 64'h123456789ABCDEF0};
    vecs[10] = '{1'b1, 1'b1, 8'h00, 3'd3, 3'd3, 64'hC0C1C2C3C4C5C6C7, 64'h7631CF8AFFFFFFFF};
    vecs[11] = '{1'b1, 1'b1, 8'h00, 3'd7, 3'd7, 64'hD0D1D2D3D4D5D6D7, 64'h318A76CFCF768A31};
    vecs[12] = '{1'b0, 1'b1, 8'h00, 3'd1, 3'd1, 64'hE0E1E2E3E4E5E6E7, 64'hB0B1B2B3B4B5B6B7};
    vecs[13] = '{1'b0, 1'b0, 8'h00, 3'd0, 3'd3, 64'h0, 64'hC0C1C2C3C4C5C6C7};
    vecs[14] = '{1'b0, 1'b0, 8'h00, 3'd0, 3'd7, 64'h0, 64'hD0D1D2D3D4D5D6D7};
    vecs[15] = '{1'b1, 1'b0, 8'h00, 3'd0, 3'd1, 64'h0, 64'hE0E1E2E3E4E5E6E7};
    vecs[16] = '{1'b0, 1'b1, 8'hFF, 3'd7, 3'd7, 64'h0, 64'hD0D1D2D3D4D5D6D7};
    vecs[17] = '{1'b1, 1'b0, 8'h00, 3'd0, 3'd7, 64'h0, 64'h318A76CFCF768A31};
    vecs[18] = '{1'b1, 1'b1, 8'h5A, 3'd0, 3'd0, 64'h0123456789ABCDEF, 64'h0};
    vecs[19] = '{1'b0, 1'b0, 8'h00, 3'd0, 3'd0, 64'h0, 64'h0100450000AB00EF};

    bus.rnw       = 1'b0;
    bus.din_valid = 1'b0;
    bus.be        = 8'hFF;
    bus.wa        = 3'd0;
    bus.ra        = 3'd0;
    bus.di        = 64'h0;
    rst_n         = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_dout", bus.dout, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i), bus.dout, vecs[i].expDout);
    end

    // Asynchronous reset mid-run: dout (currently nonzero) must clear without a clock edge.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_dout", bus.dout, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int a = 0; a < 8; a++) begin
      readCheck($sformatf("post_reset_bank1_%0d", a), 1'b1, a[2:0], 64'h0);
      readCheck($sformatf("post_reset_bank2_%0d", a), 1'b0, a[2:0], 64'h0);
    end

    // Reset after half a block has been written into bank1.
    for (int a = 0; a < 4; a++) begin
      writeOnly(1'b0, a[2:0], 64'hA0A0A0A0A0A0A0A0 + 64'(a));
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #4;
    rst_n = 1'b1;
    for (int a = 0; a < 8; a++) begin
      readCheck($sformatf("midblock_bank1_%0d", a), 1'b1, a[2:0], 64'h0);
    end

    writeOnly(1'b0, 3'd5, 64'h5A5A0F0F33CC6699);
    readCheck("resume_write_bank1_5", 1'b1, 3'd5, 64'h5A5A0F0F33CC6699);
    writeOnly(1'b1, 3'd2, 64'h0011223344556677);
    readCheck("resume_write_bank2_2", 1'b0, 3'd2, 64'h0011223344556677);
    readCheck("resume_bank1_4_clear", 1'b1, 3'd4, 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
